// File: rtl/mem_arbiter_pkg.sv
// Shared LC-3b types used by the memory arbiter: word, byte-enable mask and arbiter state.
package lc3b_types;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned WMASK_W = 2;

  typedef logic [WORD_W-1:0]  lc3b_word;
  typedef logic [WMASK_W-1:0] lc3b_mem_wmask;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT_I,
    ARB_GRANT_D
  } lc3b_arb_state;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one LC-3b memory port between instruction fetch and data accesses, one transaction per grant.
// Optional MEM_ARB_RR_EN: round-robin on ties; default build gives data fixed priority.
module mem_arbiter
  import lc3b_types::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_read,
  input  logic [WORD_W-1:0]  i_address,
  output logic [WORD_W-1:0]  i_rdata,
  output logic               i_resp,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [WORD_W-1:0]  d_address,
  input  logic [WORD_W-1:0]  d_wdata,
  input  logic [WMASK_W-1:0] d_wmask,
  output logic [WORD_W-1:0]  d_rdata,
  output logic               d_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [WORD_W-1:0]  pmem_address,
  output logic [WORD_W-1:0]  pmem_wdata,
  output logic [WMASK_W-1:0] pmem_wmask,
  input  logic [WORD_W-1:0]  pmem_rdata,
  input  logic               pmem_resp
);

  lc3b_arb_state state;
  lc3b_arb_state state_next;
  logic          d_req;
  logic          tie_pick_i;

  assign d_req   = d_read | d_write;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

`ifdef MEM_ARB_RR_EN
  // Last served requester; starts at 1 so fetch wins the first tie.
  logic last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b1;
    end else if (d_resp) begin
      last_d <= 1'b1;
    end else if (i_resp) begin
      last_d <= 1'b0;
    end
  end

  assign tie_pick_i = last_d;
`else
  assign tie_pick_i = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grants last exactly one pmem transaction; every grant returns through IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      ARB_IDLE: begin
        if (i_read && d_req) begin
          state_next = tie_pick_i ? ARB_GRANT_I : ARB_GRANT_D;
        end else if (i_read) begin
          state_next = ARB_GRANT_I;
        end else if (d_req) begin
          state_next = ARB_GRANT_D;
        end
      end
      ARB_GRANT_I: if (pmem_resp) state_next = ARB_IDLE;
      ARB_GRANT_D: if (pmem_resp) state_next = ARB_IDLE;
      default:     state_next = ARB_IDLE;
    endcase
  end

  // Live mux of the granted requester onto the memory port; write wins over read.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    pmem_wmask   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    unique case (state)
      ARB_GRANT_I: begin
        pmem_read    = 1'b1;
        pmem_address = i_address;
        pmem_wmask   = WMASK_W'(2'b11);
        i_resp       = pmem_resp;
      end
      ARB_GRANT_D: begin
        pmem_address = d_address;
        if (d_write) begin
          pmem_write = 1'b1;
          pmem_wdata = d_wdata;
          pmem_wmask = d_wmask;
        end else begin
          pmem_read  = 1'b1;
          pmem_wmask = WMASK_W'(2'b11);
        end
        d_resp = pmem_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_read;
  logic [15:0] i_address;
  logic [15:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [15:0] d_address;
  logic [15:0] d_wdata;
  logic [1:0]  d_wmask;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;

  int checks = 0;
  int errors = 0;

  // Model: who owns the memory port (0 none, 1 fetch, 2 data) and who was served last.
  int owner;
  bit last_was_d;
  bit done_i;
  bit done_d;
  int i_pulses;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner      = 0;
    last_was_d = 1'b1;
  endtask

  // Compare every output against what the current owner and live inputs imply.
  task automatic check_all();
    bit wr_d;
    wr_d = (owner == 2) && d_write;
    chk("pmem_read",  16'(pmem_read),  16'((owner == 1) || (owner == 2 && !d_write)));
    chk("pmem_write", 16'(pmem_write), 16'(wr_d));
    chk("pmem_address", pmem_address,
        (owner == 1) ? i_address : (owner == 2) ? d_address : 16'h0000);
    chk("pmem_wmask", 16'(pmem_wmask),
        (owner == 0) ? 16'h0 : wr_d ? 16'(d_wmask) : 16'h3);
    if (owner == 0 || wr_d) chk("pmem_wdata", pmem_wdata, wr_d ? d_wdata : 16'h0000);
    chk("i_resp", 16'(i_resp), 16'(owner == 1 && pmem_resp));
    chk("d_resp", 16'(d_resp), 16'(owner == 2 && pmem_resp));
    if (i_resp || d_resp) begin
      chk("i_rdata", i_rdata, pmem_rdata);
      chk("d_rdata", d_rdata, pmem_rdata);
    end
  endtask

  // One clock: check just after the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    bit dq;
    #1 check_all();
    if (i_resp) i_pulses++;
    @(posedge clk);
    done_i = 1'b0;
    done_d = 1'b0;
    dq = d_read || d_write;
    if (!rst_n) begin
      model_reset();
    end else if (owner == 0) begin
      if (i_read && dq) begin
`ifdef MEM_ARB_RR_EN
        owner = last_was_d ? 1 : 2;
`else
        owner = 2;
`endif
      end else if (i_read) owner = 1;
      else if (dq) owner = 2;
    end else if (pmem_resp) begin
      last_was_d = (owner == 2);
      done_i     = (owner == 1);
      done_d     = (owner == 2);
      owner      = 0;
    end
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int served_first;
    rst_n = 1'b0; i_read = 0; i_address = 0; d_read = 0; d_write = 0;
    d_address = 0; d_wdata = 0; d_wmask = 0; pmem_rdata = 0; pmem_resp = 0;
    model_reset();
    i_pulses = 0;
    @(negedge clk);
    #1;
    chk("reset_pmem_read", 16'(pmem_read), 16'h0);
    chk("reset_wmask", 16'(pmem_wmask), 16'h0);
    cycles(2);
    rst_n = 1'b1;
    cycle();

    // Fetch only, memory answers after three grant cycles.
    i_read = 1; i_address = 16'h0060;
    cycle();
    chk("fetch_grant_read", 16'(pmem_read), 16'h1);
    cycles(2);
    pmem_resp = 1; pmem_rdata = 16'h1234;
    #1 chk("fetch_rdata", i_rdata, 16'h1234);
    chk("fetch_resp", 16'(i_resp), 16'h1);
    cycle();
    i_read = 0; pmem_resp = 0;
    cycle();
    chk("fetch_idle_gap", 16'(pmem_read), 16'h0);

    // Data write with partial mask.
    d_write = 1; d_address = 16'h0100; d_wdata = 16'hBEEF; d_wmask = 2'b10;
    cycle();
    chk("dwrite_mask", 16'(pmem_wmask), 16'h2);
    chk("dwrite_noread", 16'(pmem_read), 16'h0);
    pmem_resp = 1;
    cycle();
    d_write = 0; pmem_resp = 0;
    cycles(2);

    // Tie: both requesters rise together, twice.
    for (int t = 0; t < 2; t++) begin
      i_read = 1; i_address = 16'h0200; d_read = 1; d_address = 16'h0300;
      cycle();
      served_first = owner;
`ifdef MEM_ARB_RR_EN
      chk("tie_winner", 16'(served_first), 16'(t == 0 ? 1 : 1));
`else
      chk("tie_winner", 16'(served_first), 16'h2);
`endif
      chk("tie_addr", pmem_address, (served_first == 1) ? 16'h0200 : 16'h0300);
      pmem_resp = 1; cycle();
      if (served_first == 1) i_read = 0; else d_read = 0;
      pmem_resp = 0; cycle();
      pmem_resp = 1; cycle();
      i_read = 0; d_read = 0; pmem_resp = 0; cycle();
    end

    // Held fetch request across three transactions.
    i_pulses = 0;
    i_read = 1; i_address = 16'h0400;
    for (int t = 0; t < 3; t++) begin
      cycle();
      pmem_resp = 1; cycle();
      pmem_resp = 0;
    end
    i_read = 0;
    cycle();
    chk("held_pulses", 16'(i_pulses), 16'd3);

    // Reset during a data write grant, then a stale response.
    d_write = 1; d_address = 16'h0500; d_wdata = 16'h5A5A; d_wmask = 2'b11;
    cycle();
    chk("pre_reset_write", 16'(pmem_write), 16'h1);
    rst_n = 0; model_reset();
    #1 chk("reset_drops_write", 16'(pmem_write), 16'h0);
    cycle();
    d_write = 0; rst_n = 1; pmem_resp = 1;
    cycle();
    chk("stale_no_dresp", 16'(d_resp), 16'h0);
    pmem_resp = 0;
    cycle();

    // Protocol violation: read and write together issues a write.
    d_read = 1; d_write = 1; d_address = 16'h0600; d_wdata = 16'h0F0F; d_wmask = 2'b01;
    cycle();
    chk("rw_write", 16'(pmem_write), 16'h1);
    chk("rw_noread", 16'(pmem_read), 16'h0);
    pmem_resp = 1; cycle();
    d_read = 0; d_write = 0; pmem_resp = 0; cycle();

    // Random traffic; requests stay stable until served, may be held afterwards.
    for (int n = 0; n < 600; n++) begin
      if (done_i && $urandom_range(1) == 0) i_read = 0;
      if (done_d && $urandom_range(1) == 0) begin d_read = 0; d_write = 0; end
      if (!i_read && $urandom_range(3) == 0) begin
        i_read = 1; i_address = 16'($urandom);
      end
      if (!d_read && !d_write && $urandom_range(3) == 0) begin
        case ($urandom_range(7))
          0:       begin d_read = 1; d_write = 1; end
          1, 2, 3: d_write = 1;
          default: d_read = 1;
        endcase
        d_address = 16'($urandom); d_wdata = 16'($urandom); d_wmask = 2'($urandom);
      end
      pmem_resp  = ($urandom_range(2) == 0);
      pmem_rdata = 16'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single LC-3b physical memory port between instruction fetch and data (LDR/STR) accesses. It sits between the CPU control/datapath and physical memory, and lets a split fetch/data front end drive one memory that uses the existing read/write/resp handshake. A grant is held for exactly one memory transaction, then released.

## Interface
Parameters:
- none; widths come from `lc3b_types` (`lc3b_word` = 16 bits, `lc3b_mem_wmask` = 2 bits).

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_read`  in  1  instruction fetch read request.
- `i_address`  in  16  fetch address.
- `i_rdata`  out  16  fetch read data.
- `i_resp`  out  1  fetch transaction done (1-cycle pulse).
- `d_read`, `d_write`  in  1 each  data read / write request.
- `d_address`  in  16  data address.
- `d_wdata`  in  16  data write data.
- `d_wmask`  in  2  data byte enable.
- `d_rdata`  out  16  data read data.
- `d_resp`  out  1  data transaction done (1-cycle pulse).
- `pmem_read`, `pmem_write`  out  1 each  physical memory commands.
- `pmem_address`  out  16  physical address.
- `pmem_wdata`  out  16  physical write data.
- `pmem_wmask`  out  2  physical byte enable.
- `pmem_rdata`  in  16  physical read data.
- `pmem_resp`  in  1  physical transaction done.

## Operation
- FSM states: `ARB_IDLE`, `ARB_GRANT_I`, `ARB_GRANT_D`. Reset state is `ARB_IDLE`.
- `ARB_IDLE`: no pmem command.
  - If only `i_read` is high, go to `ARB_GRANT_I`.
  - If only a data request (`d_read|d_write`) is high, go to `ARB_GRANT_D`.
  - If both are high, resolve per Configuration.
  - If neither is high, stay in `ARB_IDLE`.
- `ARB_GRANT_I`: drive `pmem_read=1`, `pmem_address=i_address`, `pmem_wmask=2'b11`. When `pmem_resp=1`, assert `i_resp` in the same cycle and go to `ARB_IDLE`.
- `ARB_GRANT_D`: drive `pmem_address=d_address`.
  - If `d_write`: `pmem_write=1`, `pmem_wdata=d_wdata`, `pmem_wmask=d_wmask`, `pmem_read=0`.
  - Else: `pmem_read=1`, `pmem_wmask=2'b11`.
  - `d_write` and `d_read` both high is a protocol violation; the write wins.
  - When `pmem_resp=1`, assert `d_resp` in the same cycle and go to `ARB_IDLE`.
- `i_rdata` and `d_rdata` are both wired combinationally to `pmem_rdata`. They are only meaningful while the matching resp is high.
- `pmem_resp` seen in `ARB_IDLE` is ignored: no resp is forwarded.
- Requesters hold address, data and request stable until their resp. If a request drops mid-grant, the grant is still held until `pmem_resp`, and the resp is still pulsed.
- Data-port signals are forwarded live (combinationally muxed) while granted.

## Timing
- Reset values: all pmem commands 0, `pmem_address=0`, `pmem_wdata=0`, `pmem_wmask=2'b00`, `i_resp=d_resp=0`. The same values are driven in `ARB_IDLE`.
- Latency: request sampled in `ARB_IDLE` at cycle N → pmem command asserted in cycle N+1.
- Resp forwarding: `pmem_resp` in cycle M → requester resp in cycle M (combinational); arbiter returns to `ARB_IDLE` at M+1.
- There is a mandatory one-cycle `ARB_IDLE` gap between transactions, so a stale request held through its resp cycle is never re-served.
- Minimum transaction: 1 request cycle + 1 memory-response cycle + 1 idle cycle.
- Reset mid-grant: outputs go to reset values immediately (asynchronous). The in-flight memory transaction is abandoned, and a late `pmem_resp` is ignored.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit `last_d` register records the last served requester. It is set on `d_resp` and cleared on `i_resp`.
  - Reset value of `last_d` is 1, so instruction fetch wins the first tie.
  - On a tie, the requester not last served wins.
- Undefined: fixed priority, data always wins ties (completes the in-flight LDR/STR before the next fetch). The `last_d` register is absent.

## Structure
- Add `lc3b_arb_state` (enum of the three states) to `lc3b_types`. Reuse `lc3b_word` and `lc3b_mem_wmask`.
- Single module; no sub-module. The output mux is a combinational block keyed on state; next-state logic and the state register are separate always blocks.

## Test plan
- Fetch only: `i_read=1`, `i_address=16'h0060`, memory responds after 3 cycles with `16'h1234` → `pmem_read=1` with address `0060`, then `i_resp=1` with `i_rdata=1234`, then one idle cycle.
- Data write: `d_write=1`, `d_address=16'h0100`, `d_wdata=16'hBEEF`, `d_wmask=2'b10` → `pmem_write=1` with `pmem_wmask=2'b10`; `d_resp` pulses once; `pmem_read` stays 0.
- Tie, fixed priority: `i_read` and `d_read` rise together → data is served first, then fetch after the idle gap. With `MEM_ARB_RR_EN`: fetch first, then data, then on the next tie fetch again.
- Held request: `i_read` stays high across 3 fetches → exactly 3 `i_resp` pulses, each separated by an `ARB_IDLE` cycle.
- Reset mid-grant: assert `rst_n=0` during `ARB_GRANT_D` → `pmem_write` drops the same cycle; after release, a stale `pmem_resp` produces no `d_resp`.
- Both `d_read` and `d_write` high → a write is issued and `pmem_read=0`.
